// File: rtl/bin16_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin16_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD3        = 4'd3;

  // Smallest digit count whose decimal range covers 2^bin_w - 1.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned max_v;
    longint unsigned pow10;
    int unsigned     d;
    max_v = (64'd1 << bin_w) - 64'd1;
    pow10 = 64'd1;
    d     = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (pow10 <= max_v) begin
        pow10 = pow10 * 64'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin16_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus between the counter and the display stage.
interface bin16_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     lz_mask;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, lz_mask
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, lz_mask
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD column correction: add 3 when the nibble is 5 or more, before the shift.
module bcd_digit_adj
  import bin16_to_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Combinational add-3 correction.
  always_comb begin
    digit_o = (digit_i >= BCD_ADD3_THRESH) ? (digit_i + BCD_ADD3) : digit_i;
  end

endmodule

// File: rtl/bin16_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, registered BCD and leading-zero mask.
module bin16_to_bcd_seq
  import bin16_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic               CLK100MHZ,
  input  logic               RST,
  bin16_to_bcd_seq_if.slave  io
);

  localparam int unsigned         SW     = 4 * DIGITS;
  localparam int unsigned         CW     = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0]   LZ_RST = ~DIGITS'(1);

  if (DIGITS < min_digits(BIN_W)) begin : g_bad_params
    $error("bin16_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e              state_q,   state_d;
  logic [BIN_W-1:0]    shift_q,   shift_d;
  logic [SW-1:0]       scratch_q, scratch_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic [SW-1:0]       bcd_q,     bcd_d;
  logic [DIGITS-1:0]   lz_q,      lz_d;
  logic [SW-1:0]       adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // Digit i (i >= 1) is blank when it and every higher digit are zero; units never blank.
  function automatic logic [DIGITS-1:0] lz_of(input logic [SW-1:0] v);
    logic              hz;
    logic [DIGITS-1:0] r;
    int unsigned       idx;
    hz = 1'b1;
    r  = '0;
    for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
      idx    = DIGITS - 1 - k;
      hz     = hz && (v[4*idx +: 4] == 4'd0);
      r[idx] = hz;
    end
    return r;
  endfunction

  // Next-state logic: capture on start, correct-then-shift in SHIFT, publish result on the last bit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    lz_d      = lz_q;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          shift_d   = io.bin_in;
          scratch_d = '0;
          cnt_d     = CW'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d                = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          bcd_d   = scratch_d;
          lz_d    = lz_of(scratch_d);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      lz_q      <= LZ_RST;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      lz_q      <= lz_d;
    end
  end

  assign io.busy    = (state_q == SHIFT);
  assign io.done    = (state_q == DONE);
  assign io.bcd_out = bcd_q;
  assign io.lz_mask = lz_q;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Testbench for bin16_to_bcd_seq: 16-bit and 8-bit instances, scoreboard of expected results.
module tb_bin16_to_bcd_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin16_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus16 ();
  bin16_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) bus8  ();

  bin16_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .CLK100MHZ (clk),
    .RST       (rst),
    .io        (bus16.slave)
  );

  bin16_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .CLK100MHZ (clk),
    .RST       (rst),
    .io        (bus8.slave)
  );

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  lz;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t           = t / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_lz(input int unsigned v);
    logic [4:0]  r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int i = 1; i < 5; i++) begin
      p    = p * 10;
      r[i] = (v < p);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the edge that accepts start (DUT must be idle).
  task automatic start16(input logic [15:0] v);
    @(posedge clk);
    #1;
    bus16.start  = 1'b1;
    bus16.bin_in = v;
    sb.push_back('{ref_bcd(v), ref_lz(v)});
    @(posedge clk);
    #1;
    bus16.start  = 1'b0;
    bus16.bin_in = 16'($urandom);
  endtask

  task automatic wait_done16(input string tag);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = bus16.done;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        chk({tag, "_bcd"}, 32'(bus16.bcd_out), 32'(e.bcd));
        chk({tag, "_lz"},  32'(bus16.lz_mask), 32'(e.lz));
      end
    end
  endtask

  task automatic start8(input logic [7:0] v);
    @(posedge clk);
    #1;
    bus8.start  = 1'b1;
    bus8.bin_in = v;
    @(posedge clk);
    #1;
    bus8.start  = 1'b0;
    bus8.bin_in = 8'($urandom);
  endtask

  initial begin
    exp_t e;
    int   ndone;
    int   extra;

    rst          = 1'b1;
    bus16.start  = 1'b0;
    bus16.bin_in = '0;
    bus8.start   = 1'b0;
    bus8.bin_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(bus16.busy),    32'd0);
    chk("rst_done", 32'(bus16.done),    32'd0);
    chk("rst_bcd",  32'(bus16.bcd_out), 32'h00000);
    chk("rst_lz",   32'(bus16.lz_mask), 32'b11110);
    chk("rst8_bcd", 32'(bus8.bcd_out),  32'h000);
    chk("rst8_lz",  32'(bus8.lz_mask),  32'b110);

    // Zero input with exact latency: busy for BIN_W cycles, then one done cycle
    repeat (5) @(posedge clk);
    start16(16'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("zero_busy",   32'(bus16.busy), 32'd1);
      chk("zero_nodone", 32'(bus16.done), 32'd0);
    end
    @(negedge clk);
    chk("zero_done",      32'(bus16.done), 32'd1);
    chk("zero_busy_done", 32'(bus16.busy), 32'd0);
    e = sb.pop_front();
    chk("zero_bcd",       32'(bus16.bcd_out), 32'(e.bcd));
    chk("zero_lz",        32'(bus16.lz_mask), 32'(e.lz));
    chk("zero_bcd_const", 32'(bus16.bcd_out), 32'h00000);
    chk("zero_lz_const",  32'(bus16.lz_mask), 32'b11110);
    @(negedge clk);
    chk("zero_done_pulse", 32'(bus16.done), 32'd0);

    // Maximum input and a mid-range value
    start16(16'd65535);
    wait_done16("max");
    chk("max_bcd_const", 32'(bus16.bcd_out), 32'h65535);
    chk("max_lz_const",  32'(bus16.lz_mask), 32'b00000);
    start16(16'd1234);
    wait_done16("v1234");
    chk("v1234_bcd_const", 32'(bus16.bcd_out), 32'h01234);
    chk("v1234_lz_const",  32'(bus16.lz_mask), 32'b10000);

    // Back-to-back sweep at minimum start spacing
    for (int unsigned v = 0; v < 65536; v += 61) begin
      start16(16'(v));
      wait_done16("sweep");
    end
    start16(16'd65534);
    wait_done16("sweep_top");

    // start held high through busy and done: only the first capture counts
    @(posedge clk);
    #1;
    bus16.start  = 1'b1;
    bus16.bin_in = 16'd9999;
    sb.push_back('{ref_bcd(9999), ref_lz(9999)});
    @(posedge clk);
    ndone = 0;
    for (int j = 0; j < 17; j++) begin
      #1;
      bus16.bin_in = 16'($urandom);
      @(negedge clk);
      if (bus16.done) begin
        ndone++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("spam_bcd", 32'(bus16.bcd_out), 32'(e.bcd));
          chk("spam_lz",  32'(bus16.lz_mask), 32'(e.lz));
        end
      end
      @(posedge clk);
    end
    #1;
    bus16.start = 1'b0;
    @(negedge clk);
    chk("spam_idle_busy", 32'(bus16.busy), 32'd0);
    extra = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus16.done) extra++;
    end
    chk("spam_one_done", 32'(ndone), 32'd1);
    chk("spam_no_extra", 32'(extra), 32'd0);
    if (sb.size() > 0) void'(sb.pop_front());

    // Reset during the 8th SHIFT cycle aborts without a done pulse
    start16(16'd4321);
    repeat (7) @(posedge clk);
    #1;
    rst         = 1'b1;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus16.start = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    chk("abort_busy", 32'(bus16.busy),    32'd0);
    chk("abort_done", 32'(bus16.done),    32'd0);
    chk("abort_bcd",  32'(bus16.bcd_out), 32'h00000);
    chk("abort_lz",   32'(bus16.lz_mask), 32'b11110);
    extra = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus16.done) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    start16(16'd4321);
    wait_done16("after_abort");
    chk("after_abort_const", 32'(bus16.bcd_out), 32'h04321);

    // Narrow instance: 8-bit input, 3 digits
    start8(8'd255);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("n255_busy", 32'(bus8.busy), 32'd1);
    end
    @(negedge clk);
    chk("n255_done", 32'(bus8.done),    32'd1);
    chk("n255_bcd",  32'(bus8.bcd_out), 32'h255);
    chk("n255_lz",   32'(bus8.lz_mask), 32'b000);
    @(negedge clk);
    start8(8'd7);
    ndone = 0;
    for (int n = 0; n < 30 && ndone == 0; n++) begin
      @(negedge clk);
      if (bus8.done) ndone = 1;
    end
    chk("n7_done", 32'(ndone),         32'd1);
    chk("n7_bcd",  32'(bus8.bcd_out),  32'h007);
    chk("n7_lz",   32'(bus8.lz_mask),  32'b110);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin16_to_bcd_seq.md
Name: bin16_to_bcd_seq

Overview:
- Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Sits between the free-running binary counter and the multiplexed seven-segment anode/segment controller.
- The display stage consumes the registered BCD digits and leading-zero mask, so counts show in decimal instead of hex.
- Start/busy/done handshake; one bit converted per clock.

Parameters:
- BIN_W, 16, width of binary input.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; a violation is an elaboration error.

Ports:
- CLK100MHZ  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- bin_in  in  BIN_W  binary value; captured on the edge that accepts start.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; bcd_out/lz_mask updated in the same cycle.
- bcd_out  out  4*DIGITS  packed BCD; digit 0 = [3:0] (units). Held between conversions.
- lz_mask  out  DIGITS  bit i = 1 means digit i is a leading zero (blank it). Bit 0 is always 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports CLK100MHZ, RST).
- Reset values: state IDLE, busy 0, done 0, bcd_out all zero, lz_mask = all ones except bit0 = 0. With this mask, reset displays "0".
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start = 1: load shift_reg <= bin_in, clear scratch BCD, bit_cnt <= BIN_W, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge: every scratch nibble >= 5 gets +3 (all columns in parallel, combinationally).
  - Then {scratch, shift_reg} shifts left by 1 and bit_cnt decrements.
  - On the edge where bit_cnt == 1: the post-shift scratch is written to bcd_out, lz_mask is computed from it, and the state goes to DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - Next edge returns to IDLE.
  - start is ignored in DONE.
- Latency:
  - start sampled at edge k; busy = 1 in the cycles after edges k .. k+BIN_W-1 (BIN_W cycles).
  - done = 1 in the cycle after edge k+BIN_W.
  - Minimum start-to-start spacing is BIN_W+2 cycles.
- start while busy or done: ignored, no queuing. bin_in changes after capture have no effect.
- lz_mask:
  - Bit i (i >= 1) = 1 iff digit i and all higher digits are 0.
  - Computed from the new result and registered alongside bcd_out.
- Arithmetic:
  - Scratch is 4*DIGITS bits; no nibble exceeds 9 after correction.
  - Bits shifted out of the scratch MSB are impossible under the parameter constraint.
- RST mid-conversion: abort immediately, all outputs to reset values, no done pulse. start in the same cycle as RST is ignored.
- bcd_out/lz_mask change only on done edges or RST; the display stage may sample them asynchronously to done.

Decomposition:
- Package bin16_to_bcd_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - BCD_ADD3_THRESH = 5 and BCD_ADD3 = 3 constants.
  - Function computing minimum DIGITS for a given BIN_W, used in the elaboration check.
- Sub-module bcd_digit_adj: purely combinational 4-bit in -> 4-bit out add-3-if->=5. Instantiated DIGITS times via generate.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset, then bin_in = 16'd0, start at cycle 10 -> busy high cycles 11..26, done = 1 only in cycle 27, bcd_out = 20'h00000, lz_mask = 5'b11110.
- bin_in = 16'd65535 -> bcd_out = 20'h65535, lz_mask = 5'b00000. Then bin_in = 16'd1234 -> bcd_out = 20'h01234, lz_mask = 5'b10000.
- Sweep bin_in 0..65535 with back-to-back starts every 18 cycles, checking against a reference model. Then pulse start every cycle during busy -> exactly one done per accepted start; extra starts ignored, result matches the first captured value.
- Assert RST during the 8th SHIFT cycle of a 16'd4321 conversion -> no done; bcd_out = 0, lz_mask = 5'b11110 next cycle. A new start for 16'd4321 afterwards -> bcd_out = 20'h04321.
- BIN_W = 8, DIGITS = 3: bin_in = 8'd255 -> bcd_out = 12'h255, done 9 cycles after start. bin_in = 8'd7 -> 12'h007, lz_mask = 3'b110.
